// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse command/response bytes and the init controller state encoding.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] RSP_ACK      = 8'hFA;
    localparam logic [7:0] RSP_RESEND   = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
    localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;
    localparam logic [7:0] RSP_ID       = 8'h00;

    typedef enum logic [3:0] {
        IDLE,
        SEND_RST,
        WAIT_TXRST,
        WAIT_ACK1,
        WAIT_BAT,
        WAIT_ID,
        SEND_EN,
        WAIT_TXEN,
        WAIT_ACK2,
        STREAM,
        FAIL
    } ps2_state_e;

    // States in which the response timeout is armed.
    function automatic logic is_wait_state(input ps2_state_e s);
        return (s == WAIT_TXRST) || (s == WAIT_ACK1) || (s == WAIT_BAT) ||
               (s == WAIT_ID) || (s == WAIT_TXEN) || (s == WAIT_ACK2);
    endfunction

endpackage

// File: rtl/ps2_timeout.sv
// Free-running response timer; Expired holds once the count reaches TIMEOUT_CYCLES-1.
module ps2_timeout #(
    parameter int TIMEOUT_CYCLES = 25000000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Clear,
    output logic Expired
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            cnt_q <= '0;
        end else if (cnt_q != LAST) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign Expired = (cnt_q == LAST);

endmodule

// File: rtl/ps2_mouse_init_ctrl.sv
// PS/2 mouse bring-up: reset, BAT/ID check, enable streaming, then forward packets.
module ps2_mouse_init_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 25000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic       TxWrite,
    output logic [7:0] TxData,
    input  logic       TxDone,
    input  logic       TxIdle,
    input  logic [7:0] RxData,
    input  logic       RxValid,
    output logic [7:0] StreamData,
    output logic       StreamValid,
    output logic       Ready,
    output logic       Error,
    output logic [1:0] Retries
);

    ps2_state_e state_q, state_d;
    logic       tx_write_q, tx_write_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic [7:0] stream_data_q, stream_data_d;
    logic       stream_valid_q, stream_valid_d;
    logic       ready_q, ready_d;
    logic       error_q, error_d;
    logic [1:0] retries_q, retries_d;
    logic       prev_aa_q, prev_aa_d;
    logic       restart;
    logic       can_retry;
    logic       expired;
    logic       tmo_clear;

    assign can_retry = (int'(retries_q) < MAX_RETRIES);

    always_comb begin
        state_d        = state_q;
        tx_write_d     = 1'b0;
        tx_data_d      = tx_data_q;
        stream_data_d  = stream_data_q;
        stream_valid_d = 1'b0;
        retries_d      = retries_q;
        prev_aa_d      = 1'b0;
        restart        = 1'b0;

        case (state_q)
            IDLE: state_d = SEND_RST;
            SEND_RST: begin
                if (TxIdle) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = CMD_RESET;
                    state_d    = WAIT_TXRST;
                end
            end
            WAIT_TXRST: begin
                if (TxDone) state_d = WAIT_ACK1;
                else if (RxValid || expired) restart = 1'b1;
            end
            WAIT_ACK1: begin
                if (RxValid) begin
                    if (RxData == RSP_ACK) state_d = WAIT_BAT;
                    else if (RxData == RSP_RESEND) state_d = SEND_RST;
                    else restart = 1'b1;
                end else if (expired) begin
                    restart = 1'b1;
                end
            end
            WAIT_BAT: begin
                if (RxValid) begin
                    if (RxData == RSP_BAT_OK) state_d = WAIT_ID;
                    else restart = 1'b1;
                end else if (expired) begin
                    restart = 1'b1;
                end
            end
            WAIT_ID: begin
                if (RxValid) begin
                    if (RxData == RSP_ID) state_d = SEND_EN;
                    else restart = 1'b1;
                end else if (expired) begin
                    restart = 1'b1;
                end
            end
            SEND_EN: begin
                if (TxIdle) begin
                    tx_write_d = 1'b1;
                    tx_data_d  = CMD_ENABLE;
                    state_d    = WAIT_TXEN;
                end
            end
            WAIT_TXEN: begin
                if (TxDone) state_d = WAIT_ACK2;
                else if (RxValid || expired) restart = 1'b1;
            end
            WAIT_ACK2: begin
                if (RxValid) begin
                    if (RxData == RSP_ACK) state_d = STREAM;
                    else if (RxData == RSP_RESEND) state_d = SEND_EN;
                    else restart = 1'b1;
                end else if (expired) begin
                    restart = 1'b1;
                end
            end
            STREAM: begin
                prev_aa_d = prev_aa_q;
                if (RxValid) begin
                    stream_valid_d = 1'b1;
                    stream_data_d  = RxData;
                    prev_aa_d      = (RxData == RSP_BAT_OK);
                    // AA then 00 is a fresh device announcing itself: re-enable it.
                    if (prev_aa_q && (RxData == RSP_ID)) begin
                        state_d   = SEND_EN;
                        retries_d = 2'd0;
                        prev_aa_d = 1'b0;
                    end
                end
            end
            FAIL: state_d = FAIL;
            default: state_d = IDLE;
        endcase

        if (restart) begin
            if (can_retry) begin
                retries_d = retries_q + 2'd1;
                state_d   = SEND_RST;
            end else begin
                state_d = FAIL;
            end
        end

        ready_d = (state_d == STREAM);
        error_d = (state_d == FAIL);
    end

    assign tmo_clear = (state_d != state_q) || !is_wait_state(state_q);

    ps2_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .Clk    (Clk),
        .Reset  (Reset),
        .Clear  (tmo_clear),
        .Expired(expired)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= IDLE;
            tx_write_q     <= 1'b0;
            tx_data_q      <= 8'h00;
            stream_data_q  <= 8'h00;
            stream_valid_q <= 1'b0;
            ready_q        <= 1'b0;
            error_q        <= 1'b0;
            retries_q      <= 2'd0;
            prev_aa_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            tx_write_q     <= tx_write_d;
            tx_data_q      <= tx_data_d;
            stream_data_q  <= stream_data_d;
            stream_valid_q <= stream_valid_d;
            ready_q        <= ready_d;
            error_q        <= error_d;
            retries_q      <= retries_d;
            prev_aa_q      <= prev_aa_d;
        end
    end

    assign TxWrite     = tx_write_q;
    assign TxData      = tx_data_q;
    assign StreamData  = stream_data_q;
    assign StreamValid = stream_valid_q;
    assign Ready       = ready_q;
    assign Error       = error_q;
    assign Retries     = retries_q;

endmodule

// File: tb/tb_ps2_mouse_init_ctrl.sv
// Directed bench for ps2_mouse_init_ctrl with a behavioural PS2Tx model.
module tb_ps2_mouse_init_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       TxWrite;
    logic [7:0] TxData;
    logic       TxDone = 1'b0;
    logic       TxIdle = 1'b1;
    logic [7:0] RxData = 8'h00;
    logic       RxValid = 1'b0;
    logic [7:0] StreamData;
    logic       StreamValid;
    logic       Ready;
    logic       Error;
    logic [1:0] Retries;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int tx_busy = 0;
    int wr_count = 0;
    int wr_cycle = 0;
    int done_count = 0;
    logic [7:0] wr_last = 8'h00;
    int exp_wr = 0;
    int exp_done = 0;
    int prev_cycle = 0;

    ps2_mouse_init_ctrl #(
        .TIMEOUT_CYCLES(1000),
        .MAX_RETRIES   (3)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .TxWrite    (TxWrite),
        .TxData     (TxData),
        .TxDone     (TxDone),
        .TxIdle     (TxIdle),
        .RxData     (RxData),
        .RxValid    (RxValid),
        .StreamData (StreamData),
        .StreamValid(StreamValid),
        .Ready      (Ready),
        .Error      (Error),
        .Retries    (Retries)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // PS2Tx model: a write keeps the line busy for six cycles, then pulses TxDone.
    always @(negedge Clk) begin
        TxDone <= 1'b0;
        if (tx_busy > 0) begin
            tx_busy <= tx_busy - 1;
            if (tx_busy == 1) begin
                TxDone     <= 1'b1;
                TxIdle     <= 1'b1;
                done_count <= done_count + 1;
            end
        end else if (TxWrite === 1'b1) begin
            TxIdle  <= 1'b0;
            tx_busy <= 6;
        end
        if (TxWrite === 1'b1) begin
            wr_count <= wr_count + 1;
            wr_last  <= TxData;
            wr_cycle <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(negedge Clk);
        RxData  = b;
        RxValid = 1'b1;
        @(negedge Clk);
        RxValid = 1'b0;
    endtask

    task automatic wait_write(input logic [7:0] data, input string tag);
        exp_wr++;
        for (int i = 0; i < 3000 && wr_count < exp_wr; i++) @(posedge Clk);
        check({tag, " write count"}, wr_count, exp_wr);
        check({tag, " write data"}, wr_last, data);
    endtask

    task automatic wait_done();
        exp_done++;
        for (int i = 0; i < 100 && done_count < exp_done; i++) @(posedge Clk);
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 200 && Ready !== 1'b1; i++) @(negedge Clk);
        check({tag, " ready"}, Ready, 1);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // Device replies FA AA 00 to FF, then FA to F4.
    task automatic nominal_after_ff(input string tag);
        wait_done();
        send_rx(8'hFA);
        send_rx(8'hAA);
        check({tag, " no stream during init"}, StreamValid, 0);
        send_rx(8'h00);
        wait_write(8'hF4, {tag, " enable"});
        wait_done();
        send_rx(8'hFA);
        wait_ready(tag);
    endtask

    task automatic stream_byte(input logic [7:0] b, input string tag);
        @(negedge Clk);
        RxData  = b;
        RxValid = 1'b1;
        @(negedge Clk);
        RxValid = 1'b0;
        check({tag, " valid"}, StreamValid, 1);
        check({tag, " data"}, StreamData, b);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge Clk);
        check("rst TxWrite", TxWrite, 0);
        check("rst TxData", TxData, 8'h00);
        check("rst StreamValid", StreamValid, 0);
        check("rst StreamData", StreamData, 8'h00);
        check("rst Ready", Ready, 0);
        check("rst Error", Error, 0);
        check("rst Retries", Retries, 0);
        Reset = 1'b0;

        // Nominal bring-up
        wait_write(8'hFF, "nom reset");
        nominal_after_ff("nom");
        check("nom retries", Retries, 0);
        check("nom total writes", wr_count, 2);
        check("nom error", Error, 0);

        // Resend on first FF
        do_reset();
        wait_write(8'hFF, "resend first");
        wait_done();
        send_rx(8'hFE);
        wait_write(8'hFF, "resend second");
        check("resend retries", Retries, 0);
        nominal_after_ff("resend");
        check("resend retries final", Retries, 0);

        // BAT failure then good attempt
        do_reset();
        wait_write(8'hFF, "bat first");
        wait_done();
        send_rx(8'hFA);
        send_rx(8'hFC);
        wait_write(8'hFF, "bat retry");
        check("bat retries", Retries, 1);
        nominal_after_ff("bat");
        check("bat retries final", Retries, 1);

        // Streaming and hot-plug
        stream_byte(8'h08, "stream 08");
        @(negedge Clk);
        check("stream pulse width", StreamValid, 0);
        stream_byte(8'h01, "stream 01");
        stream_byte(8'h02, "stream 02");
        check("stream ready", Ready, 1);
        stream_byte(8'hAA, "hotplug AA");
        check("hotplug ready after AA", Ready, 1);
        stream_byte(8'h00, "hotplug 00");
        check("hotplug ready drop", Ready, 0);
        check("hotplug retries clear", Retries, 0);
        wait_write(8'hF4, "hotplug enable");
        wait_done();
        send_rx(8'hFA);
        wait_ready("hotplug");

        // Reset while waiting for BAT
        do_reset();
        wait_write(8'hFF, "midbat first");
        wait_done();
        send_rx(8'hFA);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check("midbat TxWrite", TxWrite, 0);
        check("midbat TxData", TxData, 8'h00);
        check("midbat StreamValid", StreamValid, 0);
        check("midbat StreamData", StreamData, 8'h00);
        check("midbat Ready", Ready, 0);
        check("midbat Error", Error, 0);
        check("midbat Retries", Retries, 0);
        Reset = 1'b0;
        wait_write(8'hFF, "midbat fresh");

        // Silent device: retries every ~1000 cycles, then failure
        @(posedge Clk);
        prev_cycle = wr_cycle;
        for (int k = 1; k <= 3; k++) begin
            wait_write(8'hFF, "silent retry");
            check("silent retries", Retries, k);
            check("silent gap", ((wr_cycle - prev_cycle) >= 1000) && ((wr_cycle - prev_cycle) <= 1100), 1);
            prev_cycle = wr_cycle;
        end
        for (int i = 0; i < 3000 && Error !== 1'b1; i++) @(negedge Clk);
        check("silent error", Error, 1);
        check("silent retries final", Retries, 3);
        check("silent ready", Ready, 0);
        repeat (2500) @(negedge Clk);
        check("fail no more writes", wr_count, exp_wr);
        check("fail TxWrite", TxWrite, 0);
        check("fail error sticky", Error, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
